// File: rtl/sme_match_sched_pkg.sv
// Shared widths, FSM encoding and result-entry layout for the SME job scheduler.
package sme_match_sched_pkg;

  localparam int unsigned PNO_W   = 4;
  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned HIT_W   = 12;
  localparam int unsigned TO_W    = 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SRST = 2'd1,
    RUN  = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic [PNO_W-1:0]  pattern_no;
    logic [ADDR_W-1:0] addr;
  } res_entry_t;

  localparam int unsigned RES_W = $bits(res_entry_t);

endpackage

// File: rtl/sme_match_sched_if.sv
// Job, SME and result-stream signals of the scheduler; slave is the scheduler side.
interface sme_match_sched_if;
  import sme_match_sched_pkg::*;

  logic              job_req;
  logic              job_ci;
  logic              job_ack;
  logic              busy;
  logic              sme_rst;
  logic              sme_ci;
  logic              sme_valid;
  logic [PNO_W-1:0]  sme_pattern_no;
  logic [ADDR_W-1:0] sme_match_addr;
  logic              sme_finish;
  logic              res_valid;
  logic              res_ready;
  logic [PNO_W-1:0]  res_pattern_no;
  logic [ADDR_W-1:0] res_addr;
  logic [HIT_W-1:0]  hit_count;
  logic              done;
  logic              timeout;
  logic              ovf;

  modport master (
    output job_req, job_ci, sme_valid, sme_pattern_no, sme_match_addr, sme_finish, res_ready,
    input  job_ack, busy, sme_rst, sme_ci, res_valid, res_pattern_no, res_addr, hit_count,
           done, timeout, ovf
  );

  modport slave (
    input  job_req, job_ci, sme_valid, sme_pattern_no, sme_match_addr, sme_finish, res_ready,
    output job_ack, busy, sme_rst, sme_ci, res_valid, res_pattern_no, res_addr, hit_count,
           done, timeout, ovf
  );

endinterface

// File: rtl/sme_match_sched_res_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry one extra wrap bit for full/empty.
module sme_match_sched_res_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   wr_q, wr_d;
  logic [PTR_W:0]   rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_pop, do_push;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[PTR_W] != rd_q[PTR_W]) && (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
  assign dout    = mem_q[rd_q[PTR_W-1:0]];
  // A pop frees the slot that a same-cycle push into a full FIFO overwrites.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign wr_d    = do_push ? wr_q + (PTR_W+1)'(1) : wr_q;
  assign rd_d    = do_pop  ? rd_q + (PTR_W+1)'(1) : rd_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[PTR_W-1:0]] <= din;
  end

endmodule

// File: rtl/sme_match_sched.sv
// SME job scheduler: accepts a job, resets the SME, captures hits into a result FIFO.
// Optional SME_DEDUP_EN: drop hits identical to the last accepted hit of the job.
module sme_match_sched
  import sme_match_sched_pkg::*;
#(
  parameter int unsigned RST_CYC    = 2,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned TIMEOUT    = 16384
) (
  input logic              clk,
  input logic              reset,
  sme_match_sched_if.slave bus
);

  localparam logic [TO_W-1:0] RST_LAST = TO_W'(RST_CYC - 1);
  localparam logic [TO_W-1:0] TO_LAST  = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);
  localparam bit              TO_EN    = (TIMEOUT != 0);

  sched_state_e     state_q, state_d;
  logic [TO_W-1:0]  cnt_q, cnt_d;
  logic [HIT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic job_ack_q, job_ack_d, busy_q, busy_d, sme_rst_q, sme_rst_d, sme_ci_q, sme_ci_d;
  logic done_q, done_d, timeout_q, timeout_d, ovf_q, ovf_d;

  res_entry_t hit_entry, head;
  logic       push_c, pop_c, fifo_full, fifo_empty, dup_c;

  assign hit_entry = '{pattern_no: bus.sme_pattern_no, addr: bus.sme_match_addr};
  assign pop_c     = !fifo_empty && bus.res_ready;

`ifdef SME_DEDUP_EN
  res_entry_t last_q, last_d;
  logic       last_vld_q, last_vld_d;

  assign dup_c = last_vld_q && (last_q == hit_entry);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else begin
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
    end
  end

  always_comb begin
    last_d     = last_q;
    last_vld_d = last_vld_q;
    if (state_q == IDLE && bus.job_req && fifo_empty) begin
      last_vld_d = 1'b0;
    end else if (push_c) begin
      last_d     = hit_entry;
      last_vld_d = 1'b1;
    end
  end
`else
  assign dup_c = 1'b0;
`endif

  // Next-state, counters and capture decisions.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hit_cnt_d = hit_cnt_q;
    sme_ci_d  = sme_ci_q;
    ovf_d     = ovf_q;
    job_ack_d = 1'b0;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    push_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.job_req && fifo_empty) begin
          job_ack_d = 1'b1;
          sme_ci_d  = bus.job_ci;
          ovf_d     = 1'b0;
          hit_cnt_d = '0;
          cnt_d     = '0;
          state_d   = SRST;
        end
      end
      SRST: begin
        if (cnt_q == RST_LAST) begin
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      RUN: begin
        cnt_d = cnt_q + TO_W'(1);
        if (bus.sme_valid && !dup_c) begin
          if (!fifo_full || pop_c) begin
            push_c = 1'b1;
            if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + HIT_W'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
        // Finish has priority over a coincident timeout.
        if (bus.sme_finish) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (TO_EN && cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d    = (state_d != IDLE) || done_d || timeout_d;
    sme_rst_d = (state_d != RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hit_cnt_q <= '0;
      job_ack_q <= 1'b0;
      busy_q    <= 1'b0;
      sme_rst_q <= 1'b1;
      sme_ci_q  <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hit_cnt_q <= hit_cnt_d;
      job_ack_q <= job_ack_d;
      busy_q    <= busy_d;
      sme_rst_q <= sme_rst_d;
      sme_ci_q  <= sme_ci_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      ovf_q     <= ovf_d;
    end
  end

  sme_match_sched_res_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RES_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_c),
    .din   (hit_entry),
    .full  (fifo_full),
    .pop   (pop_c),
    .dout  (head),
    .empty (fifo_empty)
  );

  assign bus.job_ack        = job_ack_q;
  assign bus.busy           = busy_q;
  assign bus.sme_rst        = sme_rst_q;
  assign bus.sme_ci         = sme_ci_q;
  assign bus.done           = done_q;
  assign bus.timeout        = timeout_q;
  assign bus.ovf            = ovf_q;
  assign bus.hit_count      = hit_cnt_q;
  assign bus.res_valid      = !fifo_empty;
  assign bus.res_pattern_no = head.pattern_no;
  assign bus.res_addr       = head.addr;

endmodule

// File: tb/tb_sme_match_sched.sv
// Scoreboard bench for sme_match_sched: directed jobs, queue of expected results, decoupled monitor.
module tb_sme_match_sched;
  import sme_match_sched_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sme_match_sched_if bus ();

  sme_match_sched #(
    .RST_CYC    (2),
    .FIFO_DEPTH (16),
    .TIMEOUT    (100)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int to_cnt = 0;
  res_entry_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Result monitor: every pop is compared against the head of the expected queue.
  always @(negedge clk) begin
    res_entry_t e;
    if (reset) begin
      if (bus.done) done_cnt++;
      if (bus.timeout) to_cnt++;
      if (bus.res_valid && bus.res_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL res_unexpected: got pno=%0d addr=%0d, expected no entry",
                   bus.res_pattern_no, bus.res_addr);
        end else begin
          e = exp_q.pop_front();
          if (bus.res_pattern_no !== e.pattern_no || bus.res_addr !== e.addr) begin
            errors++;
            $display("FAIL res_entry: got pno=%0d addr=%0d, expected pno=%0d addr=%0d",
                     bus.res_pattern_no, bus.res_addr, e.pattern_no, e.addr);
          end
        end
      end
    end
  end

  task automatic start_job(input logic ci);
    int n = 0;
    bus.job_req = 1'b1;
    bus.job_ci  = ci;
    do begin tick(); n++; end while (!bus.job_ack && n < 40);
    chk("job_ack_seen", 32'(bus.job_ack), 1);
    bus.job_req = 1'b0;
    bus.job_ci  = 1'b0;
    chk("sme_ci_latched", 32'(bus.sme_ci), 32'(ci));
    chk("busy_at_ack", 32'(bus.busy), 1);
    chk("sme_rst_srst1", 32'(bus.sme_rst), 1);
    tick();
    chk("job_ack_pulse", 32'(bus.job_ack), 0);
    chk("sme_rst_srst2", 32'(bus.sme_rst), 1);
    tick();
    chk("sme_rst_run", 32'(bus.sme_rst), 0);
  endtask

  task automatic hit(input int p, input int a, input bit exp_push);
    res_entry_t e;
    e.pattern_no = PNO_W'(p);
    e.addr       = ADDR_W'(a);
    bus.sme_valid      = 1'b1;
    bus.sme_pattern_no = e.pattern_no;
    bus.sme_match_addr = e.addr;
    if (exp_push) exp_q.push_back(e);
    tick();
    bus.sme_valid = 1'b0;
  endtask

  task automatic finish_job();
    bus.sme_finish = 1'b1;
    tick();
    bus.sme_finish = 1'b0;
    chk("done_pulse", 32'(bus.done), 1);
    chk("timeout_with_done", 32'(bus.timeout), 0);
    chk("sme_rst_after_finish", 32'(bus.sme_rst), 1);
  endtask

  task automatic drain();
    int n = 0;
    bus.res_ready = 1'b1;
    while (exp_q.size() != 0 && n < 64) begin tick(); n++; end
    bus.res_ready = 1'b0;
    chk("drain_remaining", 32'(exp_q.size()), 0);
    chk("fifo_empty_after_drain", 32'(bus.res_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d0, t0;
    bit acked;
    bus.job_req = 0; bus.job_ci = 0; bus.sme_valid = 0; bus.sme_pattern_no = '0;
    bus.sme_match_addr = '0; bus.sme_finish = 0; bus.res_ready = 0;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_job_ack", 32'(bus.job_ack), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_timeout", 32'(bus.timeout), 0);
    chk("rst_ovf", 32'(bus.ovf), 0);
    chk("rst_res_valid", 32'(bus.res_valid), 0);
    chk("rst_sme_rst", 32'(bus.sme_rst), 1);
    chk("rst_sme_ci", 32'(bus.sme_ci), 0);
    chk("rst_hit_count", 32'(bus.hit_count), 0);
    tick();
    reset = 1'b1;
    tick();

    // Two hits then finish; results in order.
    start_job(1'b1);
    hit(0, 5, 1);
    hit(2, 17, 1);
    finish_job();
    chk("hit_count_two", 32'(bus.hit_count), 2);
    chk("busy_during_done", 32'(bus.busy), 1);
    tick();
    chk("done_one_cycle", 32'(bus.done), 0);
    chk("busy_after_done", 32'(bus.busy), 0);
    drain();

    // Overflow: 18 hits into a 16-deep FIFO, then pop+hit on full.
    start_job(1'b0);
    for (int i = 0; i < 18; i++) hit(i % 16, 100 + i, i < 16);
    chk("ovf_set", 32'(bus.ovf), 1);
    chk("hit_count_full", 32'(bus.hit_count), 16);
    bus.res_ready = 1'b1;
    hit(7, 999, 1);
    bus.res_ready = 1'b0;
    chk("hit_count_pop_push", 32'(bus.hit_count), 17);
    finish_job();
    chk("ovf_sticky", 32'(bus.ovf), 1);
    bus.job_req = 1'b1;
    acked = 1'b0;
    repeat (5) begin tick(); if (bus.job_ack) acked = 1'b1; end
    bus.job_req = 1'b0;
    chk("holdoff_no_ack", 32'(acked), 0);
    drain();

    // Timeout with no finish.
    start_job(1'b0);
    chk("ovf_cleared", 32'(bus.ovf), 0);
    chk("hit_count_cleared", 32'(bus.hit_count), 0);
    d0 = done_cnt; t0 = to_cnt; n = 0;
    do begin tick(); n++; end while (!bus.timeout && n < 200);
    chk("timeout_cycle", 32'(n), 100);
    chk("busy_during_timeout", 32'(bus.busy), 1);
    tick();
    chk("timeout_one_cycle", 32'(bus.timeout), 0);
    chk("busy_after_timeout", 32'(bus.busy), 0);
    chk("timeout_pulses", 32'(to_cnt - t0), 1);
    chk("no_done_on_timeout", 32'(done_cnt - d0), 0);

    // Finish on the timeout cycle: done wins.
    start_job(1'b0);
    repeat (99) tick();
    finish_job();
    tick();
    chk("no_late_timeout", 32'(bus.timeout), 0);

    // Reset in the middle of a job.
    start_job(1'b1);
    hit(3, 3, 0);
    chk("res_valid_before_rst", 32'(bus.res_valid), 1);
    d0 = done_cnt; t0 = to_cnt;
    #2 reset = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_sme_rst", 32'(bus.sme_rst), 1);
    chk("midrst_sme_ci", 32'(bus.sme_ci), 0);
    chk("midrst_res_valid", 32'(bus.res_valid), 0);
    chk("midrst_hit_count", 32'(bus.hit_count), 0);
    tick();
    reset = 1'b1;
    repeat (5) tick();
    chk("midrst_no_done", 32'(done_cnt - d0), 0);
    chk("midrst_no_timeout", 32'(to_cnt - t0), 0);
    chk("midrst_fifo_empty", 32'(bus.res_valid), 0);

    // Repeated identical hits.
    start_job(1'b0);
`ifdef SME_DEDUP_EN
    hit(1, 9, 1); hit(1, 9, 0); hit(1, 10, 1);
    finish_job();
    chk("dedup_hit_count", 32'(bus.hit_count), 2);
`else
    hit(1, 9, 1); hit(1, 9, 1); hit(1, 10, 1);
    finish_job();
    chk("dedup_hit_count", 32'(bus.hit_count), 3);
`endif
    chk("dedup_no_ovf", 32'(bus.ovf), 0);
    tick();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
